// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl
//  Purpose  : Time-of-day set controller. Debounces the mode and increment
//             pushbuttons, sequences RUN -> SET_HR -> SET_MIN -> RUN, issues
//             hour/minute increment pulses with press-and-hold auto-repeat,
//             generates the 1 s count enable and the edit-blink phase.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   system clock, rising edge
//    rstn      in   synchronous reset, active-high (1 = reset)
//    mode_key  in   raw asynchronous mode pushbutton, active-high
//    inc_key   in   raw asynchronous increment pushbutton, active-high
//    tick_en   out  one-cycle 1 s enable for the seconds counter (RUN only)
//    adj_min   out  one-cycle minute increment pulse (SET_MIN only)
//    adj_hr    out  one-cycle hour increment pulse (SET_HR only)
//    mode      out  0 RUN, 1 SET_HR, 2 SET_MIN
//    blink_on  out  display-blank phase, 1 = show digits
// ============================================================================
module clock_set_ctrl #(
    parameter int CLK_DIV     = 50000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int REP_CYCLES  = 12500000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic       tick_en,
    output logic       adj_min,
    output logic       adj_hr,
    output logic [1:0] mode,
    output logic       blink_on
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_HALF_DIV = CLK_DIV / 2;
    localparam int c_RPT_MAX  = (HOLD_CYCLES > REP_CYCLES)
                                ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                                : ((REP_CYCLES  > 2) ? REP_CYCLES  : 2);

    localparam int c_PRESC_W = $clog2(CLK_DIV);
    localparam int c_DEB_W   = $clog2(DEB_CYCLES);
    localparam int c_BLINK_W = $clog2(c_HALF_DIV);
    localparam int c_RPT_W   = $clog2(c_RPT_MAX);

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLK_DIV - 1);
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(c_HALF_DIV - 1);
    localparam logic [c_RPT_W-1:0]   c_HOLD_LAST  = c_RPT_W'(HOLD_CYCLES - 1);
    localparam logic [c_RPT_W-1:0]   c_REP_LAST   = c_RPT_W'(REP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Key conditioning: bit 0 = mode key, bit 1 = inc key
    // ------------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = {inc_key, mode_key};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic [1:0]         r_sync;
        logic               r_level;
        logic               r_level_q;
        logic [c_DEB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rstn) begin
                r_sync    <= 2'b00;
                r_level   <= 1'b0;
                r_level_q <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync    <= {r_sync[0], w_raw[gi]};
                r_level_q <= r_level;
                // Level follows the input only after it has disagreed for
                // DEB_CYCLES consecutive samples; any agreement restarts.
                if (r_sync[1] != r_level) begin
                    if (r_cnt == c_DEB_LAST) begin
                        r_level <= r_sync[1];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // Press event: the cycle right after the debounced level rises.
        assign w_press[gi] = r_level & ~r_level_q;
    end

    logic w_mode_evt;
    logic w_inc_evt;
    logic w_inc_level;

    assign w_mode_evt  = w_press[0];
    assign w_inc_evt   = w_press[1];
    assign w_inc_level = g_key[1].r_level;

    // ------------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_mode_evt) begin
            case (r_state)
                ST_RUN:    w_state_next = ST_SET_HR;
                ST_SET_HR: w_state_next = ST_SET_MIN;
                default:   w_state_next = ST_RUN;
            endcase
        end
    end

    logic w_in_set;
    assign w_in_set = (r_state != ST_RUN);

    // ------------------------------------------------------------------------
    // Auto-repeat. Only a press accepted in a set mode arms it, so a key
    // held across a mode change or reset stays silent until re-pressed.
    // r_rpt_phase: 0 = waiting out the initial hold, 1 = repeating.
    // ------------------------------------------------------------------------
    logic               r_rpt_act;
    logic               r_rpt_phase;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               w_rpt_fire;
    logic               w_adj_fire;

    assign w_rpt_fire = r_rpt_act & w_inc_level &
                        (r_rpt_cnt == (r_rpt_phase ? c_REP_LAST : c_HOLD_LAST));

    // A simultaneous mode event takes priority over any increment.
    assign w_adj_fire = w_in_set & ~w_mode_evt & (w_inc_evt | w_rpt_fire);

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_rpt_act   <= 1'b0;
            r_rpt_phase <= 1'b0;
            r_rpt_cnt   <= '0;
        end else if (w_mode_evt || !w_inc_level || !w_in_set) begin
            r_rpt_act   <= 1'b0;
            r_rpt_phase <= 1'b0;
            r_rpt_cnt   <= '0;
        end else if (w_inc_evt) begin
            r_rpt_act   <= 1'b1;
            r_rpt_phase <= 1'b0;
            r_rpt_cnt   <= '0;
        end else if (r_rpt_act) begin
            if (w_rpt_fire) begin
                r_rpt_phase <= 1'b1;
                r_rpt_cnt   <= '0;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // 1 s prescaler. Free-running in every mode; restarts when leaving
    // SET_MIN so the first second after an edit is a full one.
    // ------------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_presc <= '0;
        end else if ((r_state == ST_SET_MIN) && w_mode_evt) begin
            r_presc <= '0;
        end else if (r_presc == c_PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Blink phase: toggles every CLK_DIV/2 in set modes, restarts visible
    // on every mode change and every increment.
    // ------------------------------------------------------------------------
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (w_mode_evt || w_adj_fire || !w_in_set) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered pulse outputs
    // ------------------------------------------------------------------------
    logic r_tick;
    logic r_adj_hr;
    logic r_adj_min;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_tick    <= 1'b0;
            r_adj_hr  <= 1'b0;
            r_adj_min <= 1'b0;
        end else begin
            // Suppressed on the cycle RUN is left so no tick lands in a set mode.
            r_tick    <= (r_presc == c_PRESC_LAST) && (r_state == ST_RUN) && !w_mode_evt;
            r_adj_hr  <= w_adj_fire && (r_state == ST_SET_HR);
            r_adj_min <= w_adj_fire && (r_state == ST_SET_MIN);
        end
    end

    assign tick_en  = r_tick;
    assign adj_hr   = r_adj_hr;
    assign adj_min  = r_adj_min;
    assign mode     = r_state;
    assign blink_on = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_set_ctrl
//  Purpose  : Directed self-checking bench for clock_set_ctrl with
//             CLK_DIV=10, DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=5.
//             Inputs change and outputs are sampled on the falling edge.
//             A key raised before rising edge 1 is debounced after edge 6,
//             so its effect (mode change / adj pulse) is visible after edge 7.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    localparam int c_CLK_DIV = 10;
    localparam int c_DEB     = 4;
    localparam int c_HOLD    = 20;
    localparam int c_REP     = 5;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b1;
    logic       mode_key = 1'b0;
    logic       inc_key  = 1'b0;
    logic       tick_en;
    logic       adj_min;
    logic       adj_hr;
    logic [1:0] mode;
    logic       blink_on;

    int n_checks = 0;
    int n_fail   = 0;

    clock_set_ctrl #(
        .CLK_DIV     (c_CLK_DIV),
        .DEB_CYCLES  (c_DEB),
        .HOLD_CYCLES (c_HOLD),
        .REP_CYCLES  (c_REP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mode_key (mode_key),
        .inc_key  (inc_key),
        .tick_en  (tick_en),
        .adj_min  (adj_min),
        .adj_hr   (adj_hr),
        .mode     (mode),
        .blink_on (blink_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clean 6-cycle mode press; the new mode appears after the 7th edge.
    task automatic press_mode(input logic [1:0] from_m, input logic [1:0] to_m);
        mode_key = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            check("press_mode_hold", mode, from_m);
        end
        mode_key = 1'b0;
        step();
        check("press_mode_new", mode, to_m);
        repeat (10) step();
    endtask

    initial begin
        logic exp_p;
        int   p_last;

        // ---------------- reset state ----------------
        @(negedge clk);
        repeat (3) step();
        check("rst_mode", mode, 0);
        check("rst_tick", tick_en, 0);
        check("rst_adj_min", adj_min, 0);
        check("rst_adj_hr", adj_hr, 0);
        check("rst_blink", blink_on, 1);
        rstn = 1'b0;

        // ---------------- idle RUN: ticks at 10, 20, 30 ----------------
        for (int j = 1; j <= 35; j++) begin
            step();
            check("idle_tick", tick_en, (j % 10) == 0);
            check("idle_adj", {adj_min, adj_hr}, 0);
            check("idle_blink", blink_on, 1);
        end

        // ---------------- 3-cycle glitch is rejected ----------------
        mode_key = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            if (j == 4) mode_key = 1'b0;
            step();
            check("glitch_mode", mode, 0);
        end

        // ---------------- clean press -> SET_HR, no ticks, blinking ----------------
        press_mode(2'd0, 2'd1);
        for (int j = 18; j <= 42; j++) begin
            step();
            check("sethr_mode", mode, 1);
            check("sethr_tick", tick_en, 0);
            check("sethr_blink", blink_on, ((j - 7) / 5) % 2 == 0);
        end

        // ---------------- SET_MIN: hold inc 60 cycles ----------------
        press_mode(2'd1, 2'd2);
        inc_key = 1'b1;
        p_last  = 0;
        for (int j = 1; j <= 80; j++) begin
            if (j == 61) inc_key = 1'b0;
            step();
            exp_p = (j == 7) || (j >= 27 && j <= 62 && ((j - 27) % 5) == 0);
            if (exp_p) p_last = j;
            check("rep_adj_min", adj_min, exp_p);
            check("rep_adj_hr", adj_hr, 0);
            check("rep_tick", tick_en, 0);
            if (j >= 7) check("rep_blink", blink_on, ((j - p_last) / 5) % 2 == 0);
        end

        // ---------------- SET_MIN -> RUN at step 7, tick at 17, 27 ----------------
        mode_key = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            if (j == 7) mode_key = 1'b0;
            step();
            check("exit_mode", mode, (j < 7) ? 2 : 0);
            check("exit_tick", tick_en, (j == 17) || (j == 27));
            if (j >= 7) check("exit_blink", blink_on, 1);
        end

        // ---------------- simultaneous mode + inc in SET_HR ----------------
        press_mode(2'd0, 2'd1);
        mode_key = 1'b1;
        inc_key  = 1'b1;
        for (int j = 1; j <= 45; j++) begin
            if (j == 7) mode_key = 1'b0;
            step();
            check("both_mode", mode, (j < 7) ? 1 : 2);
            check("both_adj_hr", adj_hr, 0);
            check("both_adj_min", adj_min, 0);
        end
        inc_key = 1'b0;
        repeat (12) step();

        // re-press in SET_MIN now produces a pulse
        inc_key = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            if (j == 9) inc_key = 1'b0;
            step();
            check("repress_adj_min", adj_min, j == 7);
            check("repress_adj_hr", adj_hr, 0);
        end
        repeat (12) step();

        // ---------------- reset during auto-repeat in SET_HR ----------------
        press_mode(2'd2, 2'd0);
        press_mode(2'd0, 2'd1);
        inc_key = 1'b1;
        for (int j = 1; j <= 33; j++) begin
            step();
            check("pre_rst_adj_hr", adj_hr, (j == 7) || (j == 27) || (j == 32));
            check("pre_rst_adj_min", adj_min, 0);
        end
        rstn = 1'b1;
        step();
        check("mid_rst_mode", mode, 0);
        check("mid_rst_adj", {adj_min, adj_hr}, 0);
        check("mid_rst_tick", tick_en, 0);
        check("mid_rst_blink", blink_on, 1);
        rstn = 1'b0;
        for (int j = 35; j <= 70; j++) begin
            step();
            check("post_rst_mode", mode, 0);
            check("post_rst_adj", {adj_min, adj_hr}, 0);
            check("post_rst_tick", tick_en, (j == 44) || (j == 54) || (j == 64));
        end

        // inc still held: entering SET_HR gives no pulse
        press_mode(2'd0, 2'd1);
        for (int j = 1; j <= 40; j++) begin
            step();
            check("held_adj_hr", adj_hr, 0);
        end
        inc_key = 1'b0;
        repeat (12) step();
        inc_key = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            step();
            check("fresh_adj_hr", adj_hr, j == 7);
            check("fresh_adj_min", adj_min, 0);
        end
        inc_key = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000000, meaning clk cycles per 1 s tick; legal range >= 4.
REQ-002 Parameter DEB_CYCLES, default 1000000, meaning stable-level cycles needed to accept a key change; legal range >= 2.
REQ-003 Parameter HOLD_CYCLES, default 50000000, meaning cycles a debounced inc key must be held before auto-repeat starts.
REQ-004 Parameter REP_CYCLES, default 12500000, meaning auto-repeat period once repeating.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-high (1 = reset); sampled only on clk rising edge.
REQ-007 mode_key  in  1  raw, asynchronous, active-high mode pushbutton.
REQ-008 inc_key  in  1  raw, asynchronous, active-high increment pushbutton.
REQ-009 tick_en  out  1  one-cycle 1 s count-enable pulse for the seconds counter.
REQ-010 adj_min  out  1  one-cycle minute-increment pulse.
REQ-011 adj_hr  out  1  one-cycle hour-increment pulse.
REQ-012 mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN.
REQ-013 blink_on  out  1  0.5 s-period display-blanking phase; 1 = show digits.

Function
REQ-014 Each raw key SHALL pass through a 2-flop synchroniser, then a debouncer that updates its key level only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 Each key press event SHALL be a one-cycle pulse on the debounced 0->1 edge; releases produce no event.
REQ-016 A prescaler SHALL count 0..CLK_DIV-1 and wrap; tick_en = 1 in the single cycle where the count equals CLK_DIV-1 AND mode = RUN; otherwise 0.
REQ-017 Prescaler SHALL keep counting in all modes; tick_en is only gated, so the 1 s phase is preserved.
REQ-018 FSM: RUN -> SET_HR -> SET_MIN -> RUN, advancing one step per mode_key press event; no other transitions.
REQ-019 On the SET_MIN -> RUN transition, the prescaler SHALL reload to 0, so the first tick_en comes exactly CLK_DIV cycles later.
REQ-020 In SET_HR an inc press event SHALL drive adj_hr = 1 for one cycle; in SET_MIN it SHALL drive adj_min = 1 for one cycle.
REQ-021 In RUN, inc events SHALL be ignored.
REQ-022 Auto-repeat: while in SET_HR or SET_MIN with debounced inc held, a hold counter runs from the press event.
REQ-023 After HOLD_CYCLES, the block SHALL issue one further adj pulse and then one every REP_CYCLES until release.
REQ-024 Release or a mode change SHALL clear the hold counter within one cycle.
REQ-025 A mode_key event and an inc event in the same cycle: the mode transition wins and no adj pulse is issued.
REQ-026 A mode change while inc is held SHALL not produce a pulse in the new mode until inc is released and pressed again.
REQ-027 adj_min and adj_hr SHALL never be 1 in the same cycle.
REQ-028 Neither adj output SHALL ever be 1 in RUN.
REQ-029 tick_en SHALL be 0 in any cycle where adj_min or adj_hr is 1.
REQ-030 blink_on SHALL toggle every CLK_DIV/2 cycles (integer division) in SET_HR and SET_MIN, and is forced to 1 in RUN.
REQ-031 blink_on SHALL be set to 1 and its counter cleared on every mode transition and on every adj pulse, so the digit is visible immediately after an edit.
REQ-032 All outputs SHALL be registered.
REQ-033 Latency from the debounced edge to the adj pulse SHALL be exactly 1 cycle.
REQ-034 Counter widths SHALL be derived with $clog2 from the parameters; no counter may overflow for any legal parameter value.

Reset
REQ-035 With rstn = 1 at a clk edge, the block SHALL set: mode = 0 (RUN), tick_en = 0, adj_min = 0, adj_hr = 0, blink_on = 1.
REQ-036 Reset SHALL also clear the prescaler, blink counter, hold counter, debounce counters and synchronisers.
REQ-037 Debounced key levels SHALL reset to 0, so a key held through reset yields a press event only after DEB_CYCLES of stable 1 following release of reset.
REQ-038 Reset asserted mid-edit or mid-repeat SHALL abort the operation: no adj pulse in the reset cycle or the following cycle.

Verification (CLK_DIV=10, DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=5)
REQ-039 Idle RUN after reset: tick_en pulses at cycles 10, 20 and 30 after reset release; adj outputs stay 0; blink_on stays 1.
REQ-040 mode_key glitch of 3 cycles high -> no mode change; a clean press of 6 cycles -> mode goes 0 to 1 (SET_HR); tick_en stays 0 while mode = 1.
REQ-041 In SET_MIN, hold inc 60 cycles -> adj_min pulses 1 cycle after the debounced edge, then at +20, +25, +30 ... until release; adj_hr stays 0.
REQ-042 SET_MIN -> RUN transition at cycle T -> first tick_en at cycle T+10.
REQ-043 mode_key and inc debounced edges in the same cycle while in SET_HR -> mode becomes 2; adj_hr = 0; adj_min = 0.
REQ-044 Assert rstn for 1 cycle during auto-repeat in SET_HR -> mode = 0 next cycle; no adj pulse; inc still held produces no event until released and pressed again.
